// File: rtl/chan_pkt_framer.sv
// Packet framer for the channelizer stream: header, payload words and optional trailer.
// Optional trailer word enabled by defining CHAN_PKT_FRAMER_TRAILER_EN.
module chan_pkt_framer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [31:0]          s_axis_tdata,
    input  logic [15:0]          s_axis_tuser,
    input  logic                 s_axis_tlast,
    input  logic [CNT_WIDTH-1:0] max_len,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic [7:0]           trunc_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
`ifdef CHAN_PKT_FRAMER_TRAILER_EN
        TRAILER = 2'd3,
`endif
        DISCARD = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [7:0]           seq_q, seq_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] max_len_q, max_len_d;
    logic [7:0]           trunc_cnt_q, trunc_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
`ifdef CHAN_PKT_FRAMER_TRAILER_EN
    logic                 trunc_q, trunc_d;
`endif

    logic                 out_free;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH-1:0] limit;
    logic                 at_limit;

    assign out_free = !out_valid_q || m_axis_tready;
    assign cnt_inc  = cnt_q + CNT_ONE;
    // An unlimited packet is capped at the largest count the counter can hold.
    assign limit    = (max_len_q == '0) ? '1 : max_len_q;
    assign at_limit = (cnt_inc == limit);

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;
    assign trunc_count   = trunc_cnt_q;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        seq_d         = seq_q;
        cnt_d         = cnt_q;
        max_len_d     = max_len_q;
        trunc_cnt_d   = trunc_cnt_q;
        out_valid_d   = out_valid_q && !m_axis_tready;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        s_axis_tready = 1'b0;
`ifdef CHAN_PKT_FRAMER_TRAILER_EN
        trunc_d       = trunc_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (s_axis_tvalid && out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {SYNC_BYTE, seq_q, s_axis_tuser};
                    out_last_d  = 1'b0;
                    seq_d       = seq_q + 8'd1;
                    max_len_d   = max_len;
                    cnt_d       = '0;
`ifdef CHAN_PKT_FRAMER_TRAILER_EN
                    trunc_d     = 1'b0;
`endif
                    state_d     = PAYLOAD;
                end
            end

            PAYLOAD: begin
                s_axis_tready = out_free;
                if (s_axis_tvalid && out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = s_axis_tdata;
                    cnt_d       = cnt_inc;
`ifdef CHAN_PKT_FRAMER_TRAILER_EN
                    out_last_d  = 1'b0;
                    if (s_axis_tlast) begin
                        state_d = TRAILER;
                    end else if (at_limit) begin
                        trunc_d = 1'b1;
                        if (trunc_cnt_q != 8'hFF) trunc_cnt_d = trunc_cnt_q + 8'd1;
                        state_d = TRAILER;
                    end
`else
                    out_last_d  = s_axis_tlast || at_limit;
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end else if (at_limit) begin
                        if (trunc_cnt_q != 8'hFF) trunc_cnt_d = trunc_cnt_q + 8'd1;
                        state_d = DISCARD;
                    end
`endif
                end
            end

`ifdef CHAN_PKT_FRAMER_TRAILER_EN
            TRAILER: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {trunc_q, 15'd0, 16'(cnt_q)};
                    out_last_d  = 1'b1;
                    state_d     = trunc_q ? DISCARD : IDLE;
                end
            end
`endif

            DISCARD: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            cnt_q       <= '0;
            max_len_q   <= '0;
            trunc_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
`ifdef CHAN_PKT_FRAMER_TRAILER_EN
            trunc_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            cnt_q       <= cnt_d;
            max_len_q   <= max_len_d;
            trunc_cnt_q <= trunc_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
`ifdef CHAN_PKT_FRAMER_TRAILER_EN
            trunc_q     <= trunc_d;
`endif
        end
    end

endmodule

// File: doc/chan_pkt_framer.md
CHAN_PKT_FRAMER -- requirements
Module: chan_pkt_framer

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the constant placed in header bits [31:24].
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the width of the payload word counter and of max_len.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports s_axis_tvalid/s_axis_tready, input/output, 1/1, the channelizer output stream handshake.
REQ-006 SHALL have port s_axis_tdata, input, 32, the I/Q sample: Real in [31:16], Imag in [15:0].
REQ-007 SHALL have port s_axis_tuser, input, 16, the bin index of the sample.
REQ-008 SHALL have port s_axis_tlast, input, 1, marking the last word of a payload.
REQ-009 SHALL have port max_len, input, CNT_WIDTH, the maximum payload words per packet; 0 means unlimited.
REQ-010 SHALL have ports m_axis_tvalid/m_axis_tready, output/input, 1/1, the framed output stream handshake.
REQ-011 SHALL have port m_axis_tdata, output, 32, carrying header, payload or trailer words.
REQ-012 SHALL have port m_axis_tlast, output, 1, marking the last word of a framed packet.
REQ-013 SHALL have port trunc_count, output, 8, a saturating count of truncated packets.

Function
- REQ-014 SHALL implement states IDLE, PAYLOAD, DISCARD and TRAILER; TRAILER exists only when the macro in REQ-029 is defined.
- REQ-015 SHALL drive the outputs from a single output register: m_axis_tvalid, m_axis_tdata and m_axis_tlast are registered.
  - The register loads when (!m_axis_tvalid || m_axis_tready).
  - The register holds its contents while m_axis_tvalid=1 and m_axis_tready=0.
- REQ-016 In IDLE with s_axis_tvalid=1 and the output register free, SHALL load the header {SYNC_BYTE, seq[7:0], s_axis_tuser}.
  - In that cycle, SHALL keep s_axis_tready=0 and latch max_len, then enter PAYLOAD.
  - The first payload word therefore transfers at the earliest one cycle after the header load.
- REQ-017 SHALL hold s_axis_tready=0 in IDLE and TRAILER.
- REQ-018 In PAYLOAD, SHALL drive s_axis_tready = (!m_axis_tvalid || m_axis_tready).
  - Each accepted word is copied unchanged into the output register and increments the word counter.
- REQ-019 SHALL increment seq (8-bit) once per header loaded, wrapping 255->0.
- REQ-020 In PAYLOAD, an accepted word with s_axis_tlast=1 SHALL end the payload.
  - It SHALL assert m_axis_tlast on that word (macro off), or move to TRAILER (macro on).
  - In the macro-off case, the next state is IDLE.
- REQ-021 If the latched max_len is nonzero and the accepted word is number max_len without s_axis_tlast, SHALL truncate the packet:
  - end the packet on that word as in REQ-020;
  - set the trunc flag and increment trunc_count, saturating at 255;
  - enter DISCARD (via TRAILER when the macro is on).
- REQ-022 In DISCARD, SHALL drive s_axis_tready=1 and drop every accepted word up to and including the one with s_axis_tlast=1, then return to IDLE.
  - Header loading is blocked until that return.
- REQ-023 When tlast and the max_len boundary occur on the same word, SHALL treat it as a normal end: no truncation and no DISCARD.
- REQ-024 SHALL count up to 2^CNT_WIDTH-1 words when max_len=0; on counter wrap it SHALL truncate as in REQ-021.
- REQ-025 A new header SHALL never be emitted before the previous packet's m_axis_tlast word has been loaded.

Reset
- REQ-026 While aresetn=0, the block SHALL hold the following values:
  - state=IDLE, seq=0, word counter=0, trunc flag=0, trunc_count=0;
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0.
- REQ-027 Reset asserted mid-packet SHALL discard the in-flight packet and any held output word; no partial packet is resumed.
- REQ-028 Reset SHALL deassert into IDLE, and the first header after reset SHALL carry seq=0.

Configuration
- REQ-029 With CHAN_PKT_FRAMER_TRAILER_EN defined, SHALL append one trailer word after each payload, then go to IDLE, or to DISCARD if the packet was truncated.
  - Trailer format: {trunc_flag, 15'd0, word_count[15:0]}.
  - m_axis_tlast SHALL be asserted on the trailer only.
- REQ-030 Without CHAN_PKT_FRAMER_TRAILER_EN, SHALL emit no trailer and assert m_axis_tlast on the last payload word.

Verification
- REQ-031 4-word input, tuser first=0x0010, m_axis_tready=1, macro off -> A5_00_0010 followed by the 4 words, tlast on the 4th; next header seq=1.
- REQ-032 max_len=3 with a 6-word input -> header plus 3 words, tlast on the 3rd; words 4-6 dropped with s_axis_tready=1; trunc_count=1.
- REQ-033 m_axis_tready toggled 1010... over 8-word packets -> no word lost or duplicated; tdata stable while stalled.
- REQ-034 256 one-word packets -> seq runs 0..255 then 0; 300 truncated packets -> trunc_count=255.
- REQ-035 Macro on, 5-word packet -> trailer 0x0000_0005 with tlast; max_len=2 -> trailer 0x8000_0002.
- REQ-036 aresetn pulsed low during payload word 2 -> outputs at reset values; next packet header is A5_00_xxxx.
